// File: rtl/midi_note_decoder.sv
// MIDI byte stream to monophonic note control with running status
// and a last-note-priority stack of held keys.
module midi_note_decoder #(
    parameter int STACK_DEPTH = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic [3:0] channel,
    input  logic       omni,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       key_on,
    output logic       note_load,
    output logic [4:0] held_count
);

    typedef enum logic [1:0] {
        NO_STATUS,
        WAIT_D1,
        WAIT_D2
    } state_t;

    state_t     state, state_n;
    logic [7:0] status, status_n;
    logic [6:0] d1, d1_n;
    logic       msg_done;
    logic [6:0] msg_d1, msg_d2;

    logic is_rt, is_sys, is_status, one_data;
    logic ch_ok, is_on, is_off, is_clr;

    logic       op_on, op_off, op_clr;
    logic [6:0] op_note, op_vel;

    logic [6:0] stk    [STACK_DEPTH];
    logic [6:0] stk_rm [STACK_DEPTH];
    logic [6:0] stk_on [STACK_DEPTH];
    logic [4:0] count, cnt_rm, cnt_on, hit_idx;
    logic [6:0] top_rm;
    logic       hit, was_top;

    assign is_rt     = byte_in[7:3] == 5'b11111;
    assign is_sys    = byte_in[7:3] == 5'b11110;
    assign is_status = byte_in[7] && (byte_in[7:4] != 4'hF);
    assign one_data  = (status[7:4] == 4'hC) || (status[7:4] == 4'hD);

    always_comb begin
        state_n  = state;
        status_n = status;
        d1_n     = d1;
        msg_done = 1'b0;
        msg_d1   = d1;
        msg_d2   = 7'd0;
        if (byte_valid) begin
            unique case (1'b1)
                is_rt: ;
                is_sys: begin
                    status_n = 8'd0;
                    state_n  = NO_STATUS;
                end
                is_status: begin
                    status_n = byte_in;
                    state_n  = WAIT_D1;
                end
                default: begin
                    unique case (state)
                        WAIT_D1: begin
                            d1_n   = byte_in[6:0];
                            msg_d1 = byte_in[6:0];
                            if (one_data) begin
                                msg_done = 1'b1;
                                state_n  = WAIT_D1;
                            end else begin
                                state_n = WAIT_D2;
                            end
                        end
                        WAIT_D2: begin
                            msg_done = 1'b1;
                            msg_d2   = byte_in[6:0];
                            state_n  = WAIT_D1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign ch_ok  = omni || (status[3:0] == channel);
    assign is_on  = msg_done && ch_ok && (status[7:4] == 4'h9)
                    && (msg_d2 != 7'd0);
    assign is_off = msg_done && ch_ok && ((status[7:4] == 4'h8)
                    || ((status[7:4] == 4'h9) && (msg_d2 == 7'd0)));
    assign is_clr = msg_done && ch_ok && (status[7:4] == 4'hB)
                    && (msg_d1 == 7'h7B);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= NO_STATUS;
            status  <= 8'd0;
            d1      <= 7'd0;
            op_on   <= 1'b0;
            op_off  <= 1'b0;
            op_clr  <= 1'b0;
            op_note <= 7'd0;
            op_vel  <= 7'd0;
        end else begin
            state   <= state_n;
            status  <= status_n;
            d1      <= d1_n;
            op_on   <= is_on;
            op_off  <= is_off;
            op_clr  <= is_clr;
            op_note <= msg_d1;
            op_vel  <= msg_d2;
        end
    end

    // Search, remove-and-compact, then push (dropping oldest when full).
    always_comb begin
        hit     = 1'b0;
        hit_idx = 5'd0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!hit && (5'(i) < count) && (stk[i] == op_note)) begin
                hit     = 1'b1;
                hit_idx = 5'(i);
            end
        end
        for (int i = 0; i < STACK_DEPTH; i++)
            stk_rm[i] = stk[i];
        for (int i = 0; i < STACK_DEPTH - 1; i++)
            if (hit && (5'(i) >= hit_idx))
                stk_rm[i] = stk[i+1];
        cnt_rm  = count - {4'd0, hit};
        was_top = hit && ((hit_idx + 5'd1) == count);
        top_rm  = 7'd0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if ((5'(i) + 5'd1) == cnt_rm)
                top_rm = stk_rm[i];
        for (int i = 0; i < STACK_DEPTH; i++)
            stk_on[i] = stk_rm[i];
        if (cnt_rm == 5'(STACK_DEPTH)) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++)
                stk_on[i] = stk_rm[i+1];
            stk_on[STACK_DEPTH-1] = op_note;
            cnt_on = cnt_rm;
        end else begin
            for (int i = 0; i < STACK_DEPTH; i++)
                if (5'(i) == cnt_rm)
                    stk_on[i] = op_note;
            cnt_on = cnt_rm + 5'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < STACK_DEPTH; i++)
                stk[i] <= 7'd0;
            count     <= 5'd0;
            note      <= 7'd0;
            velocity  <= 7'd0;
            note_load <= 1'b0;
        end else begin
            note_load <= 1'b0;
            if (op_on) begin
                stk       <= stk_on;
                count     <= cnt_on;
                note      <= op_note;
                velocity  <= op_vel;
                note_load <= 1'b1;
            end else if (op_off && hit) begin
                stk   <= stk_rm;
                count <= cnt_rm;
                if (was_top && (cnt_rm != 5'd0)) begin
                    note      <= top_rm;
                    note_load <= 1'b1;
                end
            end else if (op_clr) begin
                count <= 5'd0;
            end
        end
    end

    assign key_on     = count != 5'd0;
    assign held_count = count;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed self-checking bench for midi_note_decoder.
// Checks parser, stack priority, channel filter and reset behaviour.
module tb_midi_note_decoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic [3:0] channel = 4'd0;
    logic       omni = 1'b0;
    logic [6:0] note, velocity;
    logic       key_on, note_load;
    logic [4:0] held_count;

    int n_checks = 0;
    int n_fail = 0;
    int pulses, first;

    midi_note_decoder #(.STACK_DEPTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .byte_in(byte_in),
        .byte_valid(byte_valid), .channel(channel), .omni(omni),
        .note(note), .velocity(velocity), .key_on(key_on),
        .note_load(note_load), .held_count(held_count)
    );

    always #5 Clk = ~Clk;

    task automatic send(input logic [7:0] b);
        @(negedge Clk);
        byte_in = b;
        byte_valid = 1'b1;
    endtask

    // Drop valid after the last byte, then watch 4 cycles for note_load.
    task automatic flush();
        @(negedge Clk);
        byte_valid = 1'b0;
        pulses = 0;
        first = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (note_load) begin
                if (first < 0) first = k;
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if ({note, velocity} !== 14'd0) begin n_fail++; $display("FAIL reset_nv: got %h want 0", {note, velocity}); end
        n_checks++; if ({key_on, note_load, held_count} !== 7'd0) begin n_fail++; $display("FAIL reset_ctl: got %h want 0", {key_on, note_load, held_count}); end
        Reset = 1'b0;
    endtask

    task automatic test_note_on();
        send(8'h90); send(8'h3C); send(8'h64); flush();
        n_checks++; if (note !== 7'h3C) begin n_fail++; $display("FAIL on_note: got %h want 3c", note); end
        n_checks++; if (velocity !== 7'h64) begin n_fail++; $display("FAIL on_vel: got %h want 64", velocity); end
        n_checks++; if (key_on !== 1'b1) begin n_fail++; $display("FAIL on_key: got %b want 1", key_on); end
        n_checks++; if (held_count !== 5'd1) begin n_fail++; $display("FAIL on_held: got %0d want 1", held_count); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL on_pulses: got %0d want 1", pulses); end
        n_checks++; if (first !== 0) begin n_fail++; $display("FAIL on_latency: got %0d want 0", first); end
    endtask

    task automatic test_running_status();
        send(8'h40); send(8'h50); flush();
        n_checks++; if ({note, velocity} !== {7'h40, 7'h50}) begin n_fail++; $display("FAIL rs_nv: got %h want %h", {note, velocity}, {7'h40, 7'h50}); end
        n_checks++; if (held_count !== 5'd2) begin n_fail++; $display("FAIL rs_held: got %0d want 2", held_count); end
        send(8'h80); send(8'h40); send(8'h00); flush();
        n_checks++; if (note !== 7'h3C) begin n_fail++; $display("FAIL off_top_note: got %h want 3c", note); end
        n_checks++; if ({key_on, held_count} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL off_top_cnt: got %h want 21", {key_on, held_count}); end
        n_checks++; if (pulses !== 1 || first !== 0) begin n_fail++; $display("FAIL off_top_pulse: got %0d/%0d want 1/0", pulses, first); end
        n_checks++; if (velocity !== 7'h50) begin n_fail++; $display("FAIL off_vel_hold: got %h want 50", velocity); end
        send(8'h90); send(8'h3C); send(8'h00); flush();
        n_checks++; if ({key_on, held_count} !== 6'd0) begin n_fail++; $display("FAIL empty_key: got %h want 0", {key_on, held_count}); end
        n_checks++; if (note !== 7'h3C) begin n_fail++; $display("FAIL empty_note: got %h want 3c", note); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL empty_pulse: got %0d want 0", pulses); end
    endtask

    task automatic test_realtime();
        send(8'h90); send(8'hF8); send(8'h45); send(8'hFE); send(8'h70); flush();
        n_checks++; if ({note, velocity} !== {7'h45, 7'h70}) begin n_fail++; $display("FAIL rt_nv: got %h want %h", {note, velocity}, {7'h45, 7'h70}); end
        n_checks++; if (held_count !== 5'd1 || pulses !== 1) begin n_fail++; $display("FAIL rt_cnt: got %0d/%0d want 1/1", held_count, pulses); end
        send(8'h80); send(8'h45); send(8'h00); flush();
        n_checks++; if (held_count !== 5'd0) begin n_fail++; $display("FAIL rt_off: got %0d want 0", held_count); end
    endtask

    task automatic test_channel();
        channel = 4'd2;
        send(8'h91); send(8'h30); send(8'h40); flush();
        n_checks++; if ({key_on, held_count, note} !== {1'b0, 5'd0, 7'h45}) begin n_fail++; $display("FAIL ch_reject: got %h want %h", {key_on, held_count, note}, {1'b0, 5'd0, 7'h45}); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL ch_pulse: got %0d want 0", pulses); end
        omni = 1'b1;
        send(8'h91); send(8'h30); send(8'h40); flush();
        n_checks++; if ({note, held_count} !== {7'h30, 5'd1}) begin n_fail++; $display("FAIL omni: got %h want %h", {note, held_count}, {7'h30, 5'd1}); end
        send(8'h81); send(8'h30); send(8'h00); flush();
        omni = 1'b0;
        channel = 4'd0;
    endtask

    task automatic test_overflow();
        send(8'h90);
        for (int n = 8'h20; n <= 8'h28; n++) begin
            send(8'(n)); send(8'h10);
        end
        flush();
        n_checks++; if ({held_count, note} !== {5'd8, 7'h28}) begin n_fail++; $display("FAIL ovf_full: got %h want %h", {held_count, note}, {5'd8, 7'h28}); end
        send(8'h80); send(8'h20); send(8'h40); flush();
        n_checks++; if ({held_count, note, pulses[0]} !== {5'd8, 7'h28, 1'b0}) begin n_fail++; $display("FAIL ovf_dropped: got %h want %h", {held_count, note, pulses[0]}, {5'd8, 7'h28, 1'b0}); end
        send(8'h28); send(8'h40); flush();
        n_checks++; if ({held_count, note} !== {5'd7, 7'h27}) begin n_fail++; $display("FAIL ovf_top: got %h want %h", {held_count, note}, {5'd7, 7'h27}); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ovf_top_pulse: got %0d want 1", pulses); end
        send(8'h23); send(8'h40); flush();
        n_checks++; if ({held_count, note} !== {5'd6, 7'h27} || pulses !== 0) begin n_fail++; $display("FAIL ovf_mid: got %h/%0d want %h/0", {held_count, note}, pulses, {5'd6, 7'h27}); end
        send(8'hB0); send(8'h7B); send(8'h00); flush();
        n_checks++; if ({key_on, held_count, note} !== {1'b0, 5'd0, 7'h27}) begin n_fail++; $display("FAIL all_off: got %h want %h", {key_on, held_count, note}, {1'b0, 5'd0, 7'h27}); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL all_off_pulse: got %0d want 0", pulses); end
    endtask

    task automatic test_retrigger();
        send(8'h90); send(8'h10); send(8'h20); send(8'h11); send(8'h21);
        send(8'h10); send(8'h22); flush();
        n_checks++; if ({held_count, note, velocity} !== {5'd2, 7'h10, 7'h22}) begin n_fail++; $display("FAIL retrig: got %h want %h", {held_count, note, velocity}, {5'd2, 7'h10, 7'h22}); end
        send(8'h10); send(8'h00); flush();
        n_checks++; if ({held_count, note} !== {5'd1, 7'h11} || pulses !== 1) begin n_fail++; $display("FAIL retrig_off: got %h/%0d want %h/1", {held_count, note}, pulses, {5'd1, 7'h11}); end
        send(8'h11); send(8'h00); flush();
    endtask

    task automatic test_back_to_back();
        send(8'h90); send(8'h50); send(8'h01); send(8'h80); send(8'h50); send(8'h00); flush();
        n_checks++; if ({key_on, held_count, note} !== {1'b0, 5'd0, 7'h50}) begin n_fail++; $display("FAIL b2b: got %h want %h", {key_on, held_count, note}, {1'b0, 5'd0, 7'h50}); end
        send(8'hC0); send(8'h05); send(8'h06); send(8'h90); send(8'h61); send(8'h08); flush();
        n_checks++; if ({held_count, note, velocity} !== {5'd1, 7'h61, 7'h08}) begin n_fail++; $display("FAIL prog_then_on: got %h want %h", {held_count, note, velocity}, {5'd1, 7'h61, 7'h08}); end
        send(8'h90); send(8'hF0); send(8'h62); send(8'h63); flush();
        n_checks++; if ({held_count, note} !== {5'd1, 7'h61} || pulses !== 0) begin n_fail++; $display("FAIL sysex_clear: got %h/%0d want %h/0", {held_count, note}, pulses, {5'd1, 7'h61}); end
    endtask

    task automatic test_reset_mid();
        send(8'h90); send(8'h3C);
        @(negedge Clk);
        byte_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++; if ({note, velocity, key_on, note_load, held_count} !== 21'd0) begin n_fail++; $display("FAIL mid_reset: got %h want 0", {note, velocity, key_on, note_load, held_count}); end
        send(8'h50); flush();
        n_checks++; if ({held_count, note, pulses[0]} !== 13'd0) begin n_fail++; $display("FAIL no_status: got %h want 0", {held_count, note, pulses[0]}); end
        send(8'h90); send(8'h33); send(8'h44);
        @(negedge Clk);
        byte_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++; if ({note, velocity, key_on, held_count} !== 20'd0) begin n_fail++; $display("FAIL update_drop: got %h want 0", {note, velocity, key_on, held_count}); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_channel();
        test_overflow();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
